pattern_history_table: RTL and testbench

- Indexed storage of 2-bit saturating branch counters using a gshare scheme (PC XOR global history).
- Sits directly upstream of the 2-bit counter FSM. It supplies the current counter state for a branch and writes back the FSM's computed next state when the branch resolves.
- Gives fetch a registered taken/not-taken prediction one cycle after lookup.
- Owns the speculative global history register (GHR) and repairs it on mispredict.

---
 rtl/pattern_history_table.sv | 89 ++++++++
 tb/tb_pattern_history_table.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_history_table.sv
// Gshare pattern history table: 2-bit counters indexed by PC XOR global history,
// with a registered lookup port, an FSM-facing update port and GHR repair.
module pattern_history_table #(
    parameter int unsigned IDX_BITS   = 5,
    parameter int unsigned GHR_BITS   = 5,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [31:0]         lookup_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [1:0]          pred_state,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                update_valid,
    input  logic [31:0]         update_pc,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_taken,
    input  logic                update_mispredict,
    output logic [1:0]          upd_cur_state,
    input  logic [1:0]          upd_next_state
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [IDX_BITS-1:0] lidx;
    logic [IDX_BITS-1:0] uidx;
    logic [1:0]          lookup_state_c;
    logic                repair_c;
    logic                unused_pc_bits;

    // Index hashing, write-to-lookup bypass and repair detection
    always_comb begin
        lidx           = lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
        uidx           = update_pc[IDX_BITS+1:2] ^ IDX_BITS'(update_ghr);
        lookup_state_c = pht[lidx];
        if (update_valid && (uidx == lidx)) begin
            lookup_state_c = upd_next_state;
        end
        repair_c = update_valid && update_mispredict;
    end

    // Stored value only; the FSM must see the pre-write counter
    assign upd_cur_state = pht[uidx];

    assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                              update_pc[31:IDX_BITS+2], update_pc[1:0]};

    // Counter storage; saturation policy lives in the downstream FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht[i] <= INIT_STATE;
            end
        end else if (update_valid) begin
            pht[uidx] <= upd_next_state;
        end
    end

    // Prediction register and speculative history; repair squashes a same-cycle lookup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_state <= 2'b00;
            pred_ghr   <= '0;
            ghr        <= '0;
        end else begin
            if (lookup_valid && !repair_c) begin
                pred_valid <= 1'b1;
                pred_taken <= lookup_state_c[1];
                pred_state <= lookup_state_c;
                pred_ghr   <= ghr;
            end else begin
                pred_valid <= 1'b0;
            end

            if (repair_c) begin
                ghr <= GHR_BITS'({update_ghr, update_taken});
            end else if (lookup_valid) begin
                ghr <= GHR_BITS'({ghr, lookup_state_c[1]});
            end
        end
    end

endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table: directed vector table, async reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_pattern_history_table;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic [4:0]  pred_ghr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [4:0]  update_ghr;
    logic        update_taken;
    logic        update_mispredict;
    logic [1:0]  upd_cur_state;
    logic [1:0]  upd_next_state;

    pattern_history_table #(.IDX_BITS(5), .GHR_BITS(5), .INIT_STATE(2'b01)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_state(pred_state), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_ghr(update_ghr), .update_taken(update_taken),
        .update_mispredict(update_mispredict),
        .upd_cur_state(upd_cur_state), .upd_next_state(upd_next_state)
    );

    typedef struct {
        bit          lv;
        logic [31:0] lpc;
        bit          uv;
        logic [31:0] upc;
        logic [4:0]  ughr;
        bit          ut;
        bit          um;
        logic [1:0]  uns;
        logic [1:0]  ecur;
        bit          epv;
        logic [1:0]  eps;
        bit          ept;
        logic [4:0]  epg;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit clk_en = 0;

    // Reference model state
    int m_pht [32];
    int m_ghr;
    int m_pv, m_ps, m_pt, m_pg;

    initial begin
        clk = 0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_pv = 0; m_ps = 0; m_pt = 0; m_pg = 0;
    endtask

    function automatic vec_t mk(bit lv, int lpc, bit uv, int upc, int ughr, bit ut, bit um,
                                int uns, int ecur, bit epv, int eps, bit ept, int epg);
        vec_t v;
        v.lv = lv; v.lpc = 32'(lpc); v.uv = uv; v.upc = 32'(upc); v.ughr = 5'(ughr);
        v.ut = ut; v.um = um; v.uns = 2'(uns); v.ecur = 2'(ecur); v.epv = epv;
        v.eps = 2'(eps); v.ept = ept; v.epg = 5'(epg);
        return v;
    endfunction

    // One clock of traffic starting at a negedge; the model always advances alongside
    task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
        int li, ui, lstate;
        lookup_valid = v.lv; lookup_pc = v.lpc;
        update_valid = v.uv; update_pc = v.upc; update_ghr = v.ughr;
        update_taken = v.ut; update_mispredict = v.um; upd_next_state = v.uns;
        #1;
        li = int'((v.lpc >> 2) & 32'h1f) ^ m_ghr;
        ui = int'((v.upc >> 2) & 32'h1f) ^ int'(v.ughr);
        lstate = (v.uv && ui == li) ? int'(v.uns) : m_pht[li];
        if (use_model) v.ecur = 2'(m_pht[ui]);
        chk({tag, " upd_cur_state"}, 32'(upd_cur_state), 32'(v.ecur));
        @(posedge clk);
        if (v.lv && !(v.uv && v.um)) begin
            m_pv = 1; m_ps = lstate; m_pt = lstate / 2; m_pg = m_ghr;
        end else begin
            m_pv = 0;
        end
        if (v.uv && v.um) m_ghr = (int'(v.ughr) * 2 + int'(v.ut)) % 32;
        else if (v.lv)    m_ghr = (m_ghr * 2 + lstate / 2) % 32;
        if (v.uv) m_pht[ui] = int'(v.uns);
        if (use_model) begin
            v.epv = m_pv[0]; v.eps = 2'(m_ps); v.ept = m_pt[0]; v.epg = 5'(m_pg);
        end
        @(negedge clk);
        chk({tag, " pred_valid"}, 32'(pred_valid), 32'(v.epv));
        chk({tag, " pred_state"}, 32'(pred_state), 32'(v.eps));
        chk({tag, " pred_taken"}, 32'(pred_taken), 32'(v.ept));
        chk({tag, " pred_ghr"},   32'(pred_ghr),   32'(v.epg));
    endtask

    vec_t vecs [10];

    initial begin
        // Directed sequence from reset: cold lookup, train, bypass, repair priority
        vecs[0] = mk(1, 'h10, 0, 'h00, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        vecs[1] = mk(0, 'h00, 1, 'h10, 0, 0, 0, 2,  1, 0, 1, 0, 0);
        vecs[2] = mk(1, 'h10, 0, 'h00, 0, 0, 0, 0,  1, 1, 2, 1, 0);
        vecs[3] = mk(0, 'h00, 1, 'h10, 0, 0, 1, 2,  2, 0, 2, 1, 0);
        vecs[4] = mk(1, 'h10, 1, 'h10, 0, 0, 0, 3,  2, 1, 3, 1, 0);
        vecs[5] = mk(0, 'h00, 0, 'h10, 0, 0, 0, 0,  3, 0, 3, 1, 0);
        vecs[6] = mk(0, 'h00, 1, 'h10, 3, 1, 1, 1,  1, 0, 3, 1, 0);
        vecs[7] = mk(1, 'h10, 1, 'h40, 2, 1, 1, 1,  1, 0, 3, 1, 0);
        vecs[8] = mk(1, 'h10, 0, 'h00, 0, 0, 0, 0,  1, 1, 1, 0, 5);
        vecs[9] = mk(1, 'h10, 0, 'h00, 0, 0, 0, 0,  1, 1, 1, 0, 10);

        rst = 1;
        lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
        update_ghr = 0; update_taken = 0; update_mispredict = 0; upd_next_state = 0;
        model_reset();

        // Reset with no clock running
        #2;
        chk("rst pred_valid", 32'(pred_valid), 0);
        chk("rst pred_state", 32'(pred_state), 0);
        chk("rst pred_taken", 32'(pred_taken), 0);
        chk("rst pred_ghr",   32'(pred_ghr),   0);
        for (int i = 0; i < 4; i++) begin
            update_pc  = 32'(i * 28 + 4);
            update_ghr = 5'(i * 7);
            #1;
            chk("rst upd_cur_state", 32'(upd_cur_state), 1);
        end
        update_pc = 0; update_ghr = 0;

        clk_en = 1;
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            run_cycle(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Async reset between edges with an update in flight; table[4] holds 11 here
        update_valid = 1; update_pc = 'h10; update_ghr = 5'd20; upd_next_state = 2'b00;
        lookup_valid = 0; update_mispredict = 0;
        #2 rst = 1;
        #1;
        chk("async pred_valid", 32'(pred_valid), 0);
        chk("async pred_state", 32'(pred_state), 0);
        chk("async pred_taken", 32'(pred_taken), 0);
        chk("async pred_ghr",   32'(pred_ghr),   0);
        chk("async upd_cur_state", 32'(upd_cur_state), 1);
        @(negedge clk);
        rst = 0;
        model_reset();
        run_cycle(mk(1, 'h10, 0, 'h00, 0, 0, 0, 0,  1, 1, 1, 0, 0), 0, "post_rst");

        // Randomized traffic against the model; narrow PC range forces collisions
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.lv   = ($urandom_range(0, 3) != 0);
            v.lpc  = {$urandom_range(0, 3) == 0 ? 25'($urandom) : 25'd0, 5'($urandom), 2'($urandom)};
            v.uv   = ($urandom_range(0, 1) == 1);
            v.upc  = {25'($urandom), 5'($urandom), 2'($urandom)};
            v.ughr = 5'($urandom);
            v.ut   = 1'($urandom);
            v.um   = ($urandom_range(0, 4) == 0);
            v.uns  = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                v.uv  = 1;
                v.upc = 32'(((((v.lpc >> 2) & 32'h1f) ^ 32'(m_ghr) ^ 32'(v.ughr)) & 32'h1f) << 2);
            end
            run_cycle(v, 1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
